// File: rtl/traffic_frame_pkg.sv
// traffic_frame_pkg
// Shared constants and types for the lane frame serializer:
//   - default frame geometry (FRAME_W_DEF, NB_DEF) and sync byte (SYNC_DEF)
//   - lane ID encodings LANE_MID..LANE_D
//   - state_t, the serializer state encoding
//   - hdr0_byte(), the packing of the first header byte
package traffic_frame_pkg;

  localparam int         FRAME_W_DEF = 3072;
  localparam int         NB_DEF      = FRAME_W_DEF / 8;
  localparam logic [7:0] SYNC_DEF    = 8'hA5;

  localparam logic [2:0] LANE_MID = 3'd0;
  localparam logic [2:0] LANE_L   = 3'd1;
  localparam logic [2:0] LANE_R   = 3'd2;
  localparam logic [2:0] LANE_T   = 3'd3;
  localparam logic [2:0] LANE_D   = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR0,
    HDR1,
    PAYLOAD,
    CSUM
  } state_t;

  // The low nibble of the first header byte is reserved and sent as zero.
  function automatic logic [7:0] hdr0_byte(input logic [2:0] lane, input logic act);
    return {lane, act, 4'b0000};
  endfunction

endpackage

// File: rtl/traffic_frame_serializer.sv
// traffic_frame_serializer
// Takes one complete lane frame (image bits plus lane/act/prio/emerg header
// fields) and streams it out as bytes over a valid/ready link:
//   SYNC_BYTE, {lane_id,act,4'b0}, {prio,emerg}, FRAME_W/8 payload bytes MSB first
//   and, when TRAFFIC_FRAME_CSUM_EN is defined, a trailing XOR of all payload bytes.
//
// Configuration macro: TRAFFIC_FRAME_CSUM_EN (undefined by default -> no checksum byte).
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   frame_valid/frame_ready  frame handshake; frame_ready is high only in IDLE
//   frame_data               image bits, bit FRAME_W-1 is sent first
//   lane_id, act, prio, emerg  header fields, captured with the frame
//   tx_data/tx_valid/tx_ready  byte stream to the egress
//   tx_last                  marks the final byte of a frame
//   frames_sent              completed-frame count, wraps at 2^16
module traffic_frame_serializer
  import traffic_frame_pkg::*;
#(
  parameter int         FRAME_W   = FRAME_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic [2:0]         lane_id,
  input  logic               act,
  input  logic [3:0]         prio,
  input  logic [3:0]         emerg,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [15:0]        frames_sent
);

  localparam int NB    = FRAME_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  // Whether the final payload byte also ends the frame.
`ifdef TRAFFIC_FRAME_CSUM_EN
  localparam bit PAY_ENDS_FRAME = 1'b0;
`else
  localparam bit PAY_ENDS_FRAME = 1'b1;
`endif

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [2:0]         lane_q, lane_d;
  logic               act_q, act_d;
  logic [3:0]         prio_q, prio_d;
  logic [3:0]         emerg_q, emerg_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic               frame_ready_q, frame_ready_d;
  logic [15:0]        frames_q, frames_d;
`ifdef TRAFFIC_FRAME_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic accept;
  logic hs;

  assign accept  = frame_valid && frame_ready_q;
  assign hs      = tx_valid_q && tx_ready;
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    act_d      = act_q;
    prio_d     = prio_q;
    emerg_d    = emerg_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    frames_d   = frames_q;
`ifdef TRAFFIC_FRAME_CSUM_EN
    csum_d     = csum_q;
`endif

    // tx_data_q always holds the byte on the wire; each handshake loads the
    // next one, so the output stays put while the link is stalled.
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = frame_data;
          lane_d     = lane_id;
          act_d      = act;
          prio_d     = prio;
          emerg_d    = emerg;
          cnt_d      = '0;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
`ifdef TRAFFIC_FRAME_CSUM_EN
          csum_d     = 8'h00;
`endif
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (hs) begin
          tx_data_d = hdr0_byte(lane_q, act_q);
          state_d   = HDR0;
        end
      end
      HDR0: begin
        if (hs) begin
          tx_data_d = {prio_q, emerg_q};
          state_d   = HDR1;
        end
      end
      HDR1: begin
        if (hs) begin
          tx_data_d = shift_q[FRAME_W-1 -: 8];
          shift_d   = shift_q << 8;
          cnt_d     = '0;
          tx_last_d = PAY_ENDS_FRAME && (NB == 1);
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (hs) begin
`ifdef TRAFFIC_FRAME_CSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (cnt_q == CNT_LAST) begin
`ifdef TRAFFIC_FRAME_CSUM_EN
            tx_data_d = csum_q ^ tx_data_q;
            tx_last_d = 1'b1;
            state_d   = CSUM;
`else
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            frames_d   = frames_q + 16'd1;
            state_d    = IDLE;
`endif
          end else begin
            cnt_d     = cnt_nxt;
            tx_data_d = shift_q[FRAME_W-1 -: 8];
            shift_d   = shift_q << 8;
            tx_last_d = PAY_ENDS_FRAME && (cnt_nxt == CNT_LAST);
          end
        end
      end
      CSUM: begin
        if (hs) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          frames_d   = frames_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        state_d    = IDLE;
      end
    endcase

    // Registered so it rises one clock after the frame's last handshake.
    frame_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      lane_q        <= 3'd0;
      act_q         <= 1'b0;
      prio_q        <= 4'd0;
      emerg_q       <= 4'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      tx_last_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frames_q      <= 16'd0;
`ifdef TRAFFIC_FRAME_CSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      act_q         <= act_d;
      prio_q        <= prio_d;
      emerg_q       <= emerg_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      tx_last_q     <= tx_last_d;
      frame_ready_q <= frame_ready_d;
      frames_q      <= frames_d;
`ifdef TRAFFIC_FRAME_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign frame_ready = frame_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_traffic_frame_serializer.sv
// tb_traffic_frame_serializer
// Directed bench for traffic_frame_serializer: a full-size instance (FRAME_W=3072)
// for framing, backpressure, back-to-back, reset and ignored-input cases, and an
// FRAME_W=8 instance on a faster clock for the frames_sent wrap.
// Honors TRAFFIC_FRAME_CSUM_EN for the expected frame length and checksum byte.
module tb_traffic_frame_serializer;
  import traffic_frame_pkg::*;

  localparam int FW = 3072;
  localparam int NB = FW / 8;
`ifdef TRAFFIC_FRAME_CSUM_EN
  localparam int XTRA = 4;
`else
  localparam int XTRA = 3;
`endif
  localparam int FLEN   = NB + XTRA;
  localparam int FLEN_S = 1 + XTRA;

  logic clk  = 1'b0;
  logic clk2 = 1'b0;
  always #5 clk = ~clk;
  always #1 clk2 = ~clk2;

  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [FW-1:0] frame_data = '0;
  logic [2:0]    lane_id = 3'd0;
  logic          act = 1'b0;
  logic [3:0]    prio = 4'd0;
  logic [3:0]    emerg = 4'd0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_last;
  logic [15:0]   frames_sent;

  logic          s_frame_valid = 1'b0;
  logic          s_frame_ready;
  logic [7:0]    s_frame_data = 8'h00;
  logic [2:0]    s_lane_id = 3'd0;
  logic          s_act = 1'b0;
  logic [3:0]    s_prio = 4'd0;
  logic [3:0]    s_emerg = 4'd0;
  logic [7:0]    s_tx_data;
  logic          s_tx_valid;
  logic          s_tx_ready = 1'b0;
  logic          s_tx_last;
  logic [15:0]   s_frames_sent;

  traffic_frame_serializer #(.FRAME_W(FW), .SYNC_BYTE(8'hA5)) u_dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .lane_id(lane_id), .act(act), .prio(prio), .emerg(emerg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .frames_sent(frames_sent)
  );

  traffic_frame_serializer #(.FRAME_W(8), .SYNC_BYTE(8'hA5)) u_small (
    .clk(clk2), .rst(rst),
    .frame_valid(s_frame_valid), .frame_ready(s_frame_ready), .frame_data(s_frame_data),
    .lane_id(s_lane_id), .act(s_act), .prio(s_prio), .emerg(s_emerg),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .tx_last(s_tx_last),
    .frames_sent(s_frames_sent)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got[$];
  logic [7:0] sg[$];
  int         last_pos = 0;
  int         stall_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] ramp(input logic [7:0] seed);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[FW-1-8*i -: 8] = seed + 8'(i);
    return v;
  endfunction

  // Present a frame and wait (bounded) for it to be taken.
  task automatic offer(input logic [FW-1:0] d, input logic [2:0] l, input logic a,
                       input logic [3:0] p, input logic [3:0] e, input logic hold);
    int w;
    w = 0;
    frame_data  = d;
    lane_id     = l;
    act         = a;
    prio        = p;
    emerg       = e;
    frame_valid = 1'b1;
    while (frame_ready !== 1'b1 && w < 1000) begin
      step();
      w++;
    end
    chk("accept_wait", (w < 1000) ? 32'd1 : 32'd0, 32'd1);
    step();
    if (!hold) frame_valid = 1'b0;
    chk("valid_after_accept", {31'd0, tx_valid}, 32'd1);
  endtask

  // Drain bytes into got; mode 0 keeps tx_ready high, mode 1 toggles it.
  task automatic run(input int mode, input int max_bytes);
    int         cyc;
    logic [7:0] hd;
    logic       hl;
    logic       stalled;
    bit         done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 5000) begin
      tx_ready = (mode == 0) ? 1'b1 : cyc[0];
      stalled  = tx_valid && !tx_ready;
      hd       = tx_data;
      hl       = tx_last;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (tx_last) begin
          last_pos = got.size();
          done     = 1'b1;
        end
        if (got.size() >= max_bytes) done = 1'b1;
      end
      step();
      cyc++;
      if (stalled && (tx_valid !== 1'b1 || tx_data !== hd || tx_last !== hl)) stall_bad++;
    end
    chk("run_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [FW-1:0] d, input logic [2:0] l,
                             input logic a, input logic [3:0] p, input logic [3:0] e);
    int         bad;
    logic [7:0] cs;
    logic [7:0] ex;
    bad = 0;
    cs  = 8'h00;
    for (int i = 0; i < FLEN; i++) begin
      if (i == 0) ex = 8'hA5;
      else if (i == 1) ex = {l, a, 4'b0000};
      else if (i == 2) ex = {p, e};
      else if (i < NB + 3) begin
        ex = d[FW-1-8*(i-3) -: 8];
        cs = cs ^ ex;
      end else ex = cs;
      if (i >= got.size() || got[i] !== ex) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
    chk({tag, "_len"}, got.size(), FLEN);
    chk({tag, "_last_pos"}, last_pos, FLEN);
  endtask

  initial begin
    int lasts;
    int cyc2;
    int idle_bad;

    // Reset state
    step();
    step();
    chk("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_frames_sent", {16'd0, frames_sent}, 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, frame_ready}, 32'd1);

    // Basic frame, tx_ready held high
    tx_ready = 1'b1;
    got.delete();
    last_pos = 0;
    offer({NB{8'h3C}}, 3'd2, 1'b1, 4'd1, 4'd0, 1'b0);
    chk("basic_first_byte", {24'd0, tx_data}, 32'hA5);
    run(0, FLEN + 5);
    chk("basic_hdr0", {24'd0, got[1]}, 32'h50);
    chk("basic_hdr1", {24'd0, got[2]}, 32'h10);
    chk("basic_pay0", {24'd0, got[3]}, 32'h3C);
    chk("basic_payN", {24'd0, got[NB+2]}, 32'h3C);
`ifdef TRAFFIC_FRAME_CSUM_EN
    chk("basic_csum", {24'd0, got[NB+3]}, 32'h00);
`endif
    check_frame("basic", {NB{8'h3C}}, 3'd2, 1'b1, 4'd1, 4'd0);
    chk("basic_frames_sent", {16'd0, frames_sent}, 32'd1);

    // Backpressure: tx_ready toggling every cycle
    got.delete();
    last_pos  = 0;
    stall_bad = 0;
    offer({8'hFF, {(FW-8){1'b0}}}, 3'd1, 1'b0, 4'd3, 4'd5, 1'b0);
    run(1, FLEN + 5);
    chk("bp_stall_hold", stall_bad, 0);
    chk("bp_pay0", {24'd0, got[3]}, 32'hFF);
    chk("bp_pay1", {24'd0, got[4]}, 32'h00);
`ifdef TRAFFIC_FRAME_CSUM_EN
    chk("bp_csum", {24'd0, got[NB+3]}, 32'hFF);
`endif
    check_frame("bp", {8'hFF, {(FW-8){1'b0}}}, 3'd1, 1'b0, 4'd3, 4'd5);
    chk("bp_frames_sent", {16'd0, frames_sent}, 32'd2);

    // Back-to-back with frame_valid held high
    got.delete();
    last_pos = 0;
    offer({NB{8'h5A}}, LANE_MID, 1'b1, 4'd2, 4'd9, 1'b1);
    frame_data = ramp(8'h20);
    lane_id    = LANE_D;
    act        = 1'b1;
    prio       = 4'd6;
    emerg      = 4'd1;
    run(0, FLEN + 5);
    check_frame("b2b_a", {NB{8'h5A}}, 3'd0, 1'b1, 4'd2, 4'd9);
    chk("b2b_gap_ready", {31'd0, frame_ready}, 32'd1);
    chk("b2b_gap_valid", {31'd0, tx_valid}, 32'd0);
    step();
    chk("b2b_second_valid", {31'd0, tx_valid}, 32'd1);
    chk("b2b_second_sync", {24'd0, tx_data}, 32'hA5);
    frame_valid = 1'b0;
    got.delete();
    last_pos = 0;
    run(0, FLEN + 5);
    chk("b2b_hdr0", {24'd0, got[1]}, 32'h90);
    check_frame("b2b_b", ramp(8'h20), 3'd4, 1'b1, 4'd6, 4'd1);
    chk("b2b_frames_sent", {16'd0, frames_sent}, 32'd4);

    // Reset after payload byte 100
    got.delete();
    last_pos = 0;
    offer(ramp(8'h40), LANE_T, 1'b1, 4'd4, 4'd4, 1'b0);
    run(0, 3 + 101);
    chk("mid_valid_before_rst", {31'd0, tx_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_frames_sent", {16'd0, frames_sent}, 32'd0);
    chk("mid_rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_ready_after_rel", {31'd0, frame_ready}, 32'd1);
    got.delete();
    last_pos = 0;
    offer(ramp(8'h01), LANE_D, 1'b0, 4'd8, 4'd2, 1'b0);
    run(0, FLEN + 5);
    chk("mid_fresh_sync", {24'd0, got[0]}, 32'hA5);
    check_frame("mid_fresh", ramp(8'h01), 3'd4, 1'b0, 4'd8, 4'd2);
    chk("mid_frames_sent", {16'd0, frames_sent}, 32'd1);

    // frame_valid pulsed with new data during payload
    got.delete();
    last_pos = 0;
    offer(ramp(8'h10), LANE_L, 1'b0, 4'd7, 4'd3, 1'b0);
    run(0, 3 + 50);
    frame_valid = 1'b1;
    frame_data  = ramp(8'hEE);
    lane_id     = LANE_T;
    prio        = 4'hF;
    run(0, 3 + 55);
    frame_valid = 1'b0;
    run(0, FLEN + 5);
    check_frame("ign", ramp(8'h10), 3'd1, 1'b0, 4'd7, 4'd3);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b0) idle_bad++;
      step();
    end
    chk("ign_no_extra_frame", idle_bad, 0);
    chk("ign_frames_sent", {16'd0, frames_sent}, 32'd2);
    tx_ready = 1'b0;

    // frames_sent wrap on the FRAME_W=8 instance
    @(negedge clk2);
    s_frame_data  = 8'hC3;
    s_lane_id     = LANE_T;
    s_act         = 1'b0;
    s_prio        = 4'hF;
    s_emerg       = 4'h7;
    s_tx_ready    = 1'b1;
    s_frame_valid = 1'b1;
    lasts = 0;
    cyc2  = 0;
    while (lasts < 65535 && cyc2 < 500000) begin
      @(negedge clk2);
      cyc2++;
      if (s_tx_valid && s_tx_ready) begin
        if (sg.size() < FLEN_S) sg.push_back(s_tx_data);
        if (s_tx_last) lasts++;
      end
    end
    chk("wrap_budget", lasts, 65535);
    chk("small_sync", {24'd0, sg[0]}, 32'hA5);
    chk("small_hdr0", {24'd0, sg[1]}, 32'h60);
    chk("small_hdr1", {24'd0, sg[2]}, 32'hF7);
    chk("small_pay", {24'd0, sg[3]}, 32'hC3);
`ifdef TRAFFIC_FRAME_CSUM_EN
    chk("small_csum", {24'd0, sg[4]}, 32'hC3);
`endif
    @(negedge clk2);
    chk("wrap_ffff", {16'd0, s_frames_sent}, 32'hFFFF);
    cyc2 = 0;
    while (lasts < 65536 && cyc2 < 20) begin
      @(negedge clk2);
      cyc2++;
      if (s_tx_valid && s_tx_ready && s_tx_last) lasts++;
    end
    chk("wrap_last_seen", lasts, 65536);
    s_frame_valid = 1'b0;
    @(negedge clk2);
    chk("wrap_zero", {16'd0, s_frames_sent}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
